// File: rtl/gp_pkg.sv
// rtl/gp_pkg.sv - shared defaults, dump state encoding and register lookup helper
package gp_pkg;

    localparam int GP_DATA_W     = 8;
    localparam int GP_NUM_REGS   = 8;
    localparam int GP_MAX_REGS   = 32;
    localparam int GP_MAX_DATA_W = 32;
    localparam int GP_MAX_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } dump_state_e;

    typedef logic [GP_MAX_REGS*GP_MAX_DATA_W-1:0] gp_flat_t;
    typedef logic [GP_MAX_DATA_W-1:0]             gp_word_t;
    typedef logic [GP_MAX_ADDR_W-1:0]             gp_addr_t;

    // Out-of-range reads return zero; a same-cycle write to the address wins over the stored value.
    function automatic gp_word_t reg_read(
        input gp_flat_t regs,
        input int       num_regs,
        input gp_addr_t addr,
        input logic     wr_en,
        input gp_addr_t wr_addr,
        input gp_word_t wr_data
    );
        if (int'(addr) >= num_regs) begin
            return '0;
        end
        if (wr_en && (wr_addr == addr)) begin
            return wr_data;
        end
        return regs[int'(addr)*GP_MAX_DATA_W +: GP_MAX_DATA_W];
    endfunction

endpackage

// File: rtl/gp_read_port.sv
// rtl/gp_read_port.sv - one synchronous read port with write bypass and registered data/valid
module gp_read_port
    import gp_pkg::*;
#(
    parameter int DATA_W   = GP_DATA_W,
    parameter int NUM_REGS = GP_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  gp_flat_t          regs_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    gp_word_t          lookup;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;
    logic              lookup_unused;

    always_comb begin
        lookup  = reg_read(regs_i, NUM_REGS, gp_addr_t'(addr_i), wr_en_i,
                           gp_addr_t'(wr_addr_i), gp_word_t'(wr_data_i));
        valid_d = req_i;
        data_d  = req_i ? lookup[DATA_W-1:0] : data_q;
    end

    assign lookup_unused = ^lookup[GP_MAX_DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/gp_reg_file.sv
// rtl/gp_reg_file.sv - general-purpose register file with two read ports and a streaming dump port
module gp_reg_file
    import gp_pkg::*;
#(
    parameter  int DATA_W   = GP_DATA_W,
    parameter  int NUM_REGS = GP_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    gp_flat_t          regs_flat;
    gp_word_t          dump_word;
    logic              dump_unused;

    dump_state_e       state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q;
    logic              dump_valid_q;
    logic              dump_busy_q;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*GP_MAX_DATA_W +: DATA_W] = regs_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (int'(wr_addr) < NUM_REGS)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    gp_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rd_req_a),
        .addr_i    (rd_addr_a),
        .regs_i    (regs_flat),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .data_o    (rd_data_a),
        .valid_o   (rd_valid_a)
    );

    gp_read_port #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rd_req_b),
        .addr_i    (rd_addr_b),
        .regs_i    (regs_flat),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .data_o    (rd_data_b),
        .valid_o   (rd_valid_b)
    );

    always_comb begin
        dump_word = reg_read(regs_flat, NUM_REGS, gp_addr_t'(idx_q), wr_en,
                             gp_addr_t'(wr_addr), gp_word_t'(wr_data));
    end

    assign dump_unused = ^dump_word[GP_MAX_DATA_W-1:DATA_W];

    // Beat contents are captured in LOAD, so a stalled SEND is immune to later writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        idx_q       <= '0;
                        dump_busy_q <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    dump_addr_q  <= idx_q;
                    dump_data_q  <= dump_word[DATA_W-1:0];
                    dump_valid_q <= 1'b1;
                    state_q      <= SEND;
                end
                SEND: begin
                    if (dump_ready) begin
                        dump_valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            dump_busy_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dump_busy  = dump_busy_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;

endmodule

// File: doc/gp_reg_file.md
# gp_reg_file

Multi-register general-purpose register file for the simple CPU: one write port, two synchronous read ports for the datapath, and a sequential dump port that streams every register out under a valid/ready handshake. The dump port feeds the DE10 board display/debug path. It is the read-side counterpart of the single GP register write path. Registers are written by the control unit and read by the ALU operand fetch stage.

## Interface
Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 8, number of registers (≥2)
- ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_req_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  read address, port A
- rd_data_a  out  DATA_W  read data, port A
- rd_valid_a  out  1  rd_data_a is valid this cycle
- rd_req_b, rd_addr_b, rd_data_b, rd_valid_b: identical to port A
- dump_start  in  1  single-cycle pulse that starts a full dump
- dump_busy  out  1  dump in progress
- dump_valid  out  1  dump beat presented
- dump_ready  in  1  consumer accepts beat
- dump_addr  out  ADDR_W  index of presented beat
- dump_data  out  DATA_W  contents of presented beat

## Operation
- Reset: all registers, rd_data_*, rd_valid_*, dump_addr, dump_data = 0; dump_valid = dump_busy = 0; FSM = IDLE. Reset overrides every other input in the same cycle, including mid-dump.
- Write: on clock edge with wr_en=1 and wr_addr < NUM_REGS, reg[wr_addr] ← wr_data. Out-of-range writes are ignored.
- Read: rd_req_x sampled on edge. Next cycle: rd_valid_x=1 and rd_data_x = reg[rd_addr_x]. Same-cycle write to the same address is bypassed, so new wr_data is returned. Out-of-range address returns 0. With no request, rd_valid_x=0 and rd_data_x holds its last value. Ports A and B are fully independent and may hit the same address.
- Dump FSM, states IDLE, LOAD, SEND:
  - IDLE: dump_start=1 → idx←0 → LOAD. dump_start is ignored in LOAD and SEND.
  - LOAD: dump_data ← reg[idx] (with same-cycle write bypass), dump_addr ← idx → SEND.
  - SEND: dump_valid=1. On dump_valid & dump_ready: if idx = NUM_REGS-1 → IDLE, else idx←idx+1 → LOAD. Without ready, stay; dump_addr and dump_data stay stable. Later writes to the stalled register do not change dump_data.
- dump_busy = (state ≠ IDLE). Reads and writes run normally during a dump.

## Timing
- Read latency: 1 cycle, request edge to valid; back-to-back requests give one result per cycle.
- Write visibility: a write on edge N is seen by a read requested on edge N (bypass) and by all later reads.
- Dump throughput: 1 beat per 2 cycles at best (LOAD+SEND). A full dump with constant ready takes 2·NUM_REGS cycles after the start edge; dump_busy falls the cycle after the last handshake.
- dump_start on the same edge as the final handshake is ignored, because the FSM is not yet in IDLE.
- Reset asserted mid-dump: dump_valid=0 the following cycle and no further beats are presented.

## Structure
- Shared package gp_pkg: DATA_W/NUM_REGS defaults, the dump state enum (IDLE, LOAD, SEND), and a reg_read function (index + bypass + range check). The reg_read function is used by both read ports and by LOAD.
- One sub-module, gp_read_port, instantiated twice: request register, address, and data/valid output flops.
- The register array, write logic and dump FSM stay in gp_reg_file.

## Test plan
- Reset then read all 8 addresses on A and B → every rd_data=0x00, rd_valid high exactly 1 cycle after each request.
- Write 0xA5 to r3 and read r3 on A in the same cycle → next cycle rd_data_a=0xA5 (bypass). Read r3 on B one cycle later → 0xA5.
- Load r0..r7 = 0x10..0x17, pulse dump_start with ready=1 → 8 beats (addr 0..7, data 0x10..0x17), dump_busy high 16 cycles.
- Hold ready=0 for 5 cycles on beat 2 while writing 0xFF to r2 → beat 2 stays 0x12. After release, the next beat is addr 3, data 0x13.
- Reset asserted during beat 4 → next cycle dump_valid=0, dump_busy=0, all regs read 0x00. dump_start during the dump is ignored (exactly 8 beats).
- Write to addr ≥ NUM_REGS (NUM_REGS=6, addr 7) → no register changes. Read of addr 7 → 0x00.
